lpm_tbl_arbiter: RTL

Two-requester arbiter that shares the single read/write access port of the LPM route table (32 entries x 128 bits) between a host register requester (req0) and a route-update agent (req1). It grants requesters round-robin and issues one-cycle table read/write strobes. It waits for the table's registered ack and returns data or a timeout error to the granted requester. It sits between the register/agent logic and the LPM lookup block's tbl_* port.

---
 rtl/lpm_tbl_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/lpm_tbl_arbiter.sv
// Round-robin arbiter sharing the LPM route table access port between the
// host register requester (req0) and the route-update agent (req1).
module lpm_tbl_arbiter #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int TBL_ADDR_WIDTH     = 5,
    parameter int TIMEOUT_CYCLES     = 16
) (
    input  logic                            AXI_ACLK,
    input  logic                            AXI_RESET,
    input  logic                            req0_rd,
    input  logic                            req0_wr,
    input  logic [TBL_ADDR_WIDTH-1:0]       req0_addr,
    input  logic [4*C_S_AXI_DATA_WIDTH-1:0] req0_wdata,
    output logic                            req0_ack,
    output logic                            req0_err,
    output logic [4*C_S_AXI_DATA_WIDTH-1:0] req0_rdata,
    input  logic                            req1_rd,
    input  logic                            req1_wr,
    input  logic [TBL_ADDR_WIDTH-1:0]       req1_addr,
    input  logic [4*C_S_AXI_DATA_WIDTH-1:0] req1_wdata,
    output logic                            req1_ack,
    output logic                            req1_err,
    output logic [4*C_S_AXI_DATA_WIDTH-1:0] req1_rdata,
    output logic                            tbl_rd_req,
    output logic                            tbl_wr_req,
    output logic [TBL_ADDR_WIDTH-1:0]       tbl_rd_addr,
    output logic [TBL_ADDR_WIDTH-1:0]       tbl_wr_addr,
    output logic [4*C_S_AXI_DATA_WIDTH-1:0] tbl_wr_data,
    input  logic [4*C_S_AXI_DATA_WIDTH-1:0] tbl_rd_data,
    input  logic                            tbl_rd_ack,
    input  logic                            tbl_wr_ack,
    output logic                            busy,
    output logic [31:0]                     timeout_count
);

    localparam int DW = 4 * C_S_AXI_DATA_WIDTH;
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]                state;
    logic                      last_grant;
    logic                      grant;
    logic                      op_rd;
    logic                      resp_err;
    logic [TW-1:0]             timer;
    logic [TBL_ADDR_WIDTH-1:0] addr_q;
    logic [DW-1:0]             wdata_q;

    logic pend0, pend1, sel, sel_rd, sel_wr, ack_match;

    assign pend0     = req0_rd | req0_wr;
    assign pend1     = req1_rd | req1_wr;
    // On a tie the requester not served last wins; otherwise the lone pending one.
    assign sel       = (pend0 & pend1) ? ~last_grant : pend1;
    assign sel_rd    = sel ? req1_rd : req0_rd;
    assign sel_wr    = sel ? req1_wr : req0_wr;
    assign ack_match = op_rd ? tbl_rd_ack : tbl_wr_ack;

    always_ff @(posedge AXI_ACLK) begin
        if (AXI_RESET) begin
            state         <= S_IDLE;
            last_grant    <= 1'b1;
            grant         <= 1'b0;
            op_rd         <= 1'b0;
            resp_err      <= 1'b0;
            timer         <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            req0_rdata    <= '0;
            req1_rdata    <= '0;
            timeout_count <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pend0 | pend1) begin
                        grant   <= sel;
                        op_rd   <= sel_rd;
                        addr_q  <= sel ? req1_addr : req0_addr;
                        wdata_q <= sel ? req1_wdata : req0_wdata;
                        // rd and wr together is rejected without touching the table
                        if (sel_rd & sel_wr) begin
                            resp_err <= 1'b1;
                            state    <= S_RESP;
                        end else begin
                            resp_err <= 1'b0;
                            state    <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    timer <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (ack_match) begin
                        resp_err <= 1'b0;
                        state    <= S_RESP;
                        if (op_rd) begin
                            if (grant) req1_rdata <= tbl_rd_data;
                            else       req0_rdata <= tbl_rd_data;
                        end
                    end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                        resp_err <= 1'b1;
                        state    <= S_RESP;
                        if (timeout_count != 32'hFFFF_FFFF)
                            timeout_count <= timeout_count + 32'd1;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                S_RESP: begin
                    last_grant <= grant;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy        = (state != S_IDLE);
    assign tbl_rd_req  = (state == S_ISSUE) &  op_rd;
    assign tbl_wr_req  = (state == S_ISSUE) & ~op_rd;
    assign tbl_rd_addr = addr_q;
    assign tbl_wr_addr = addr_q;
    assign tbl_wr_data = wdata_q;

    assign req0_ack = (state == S_RESP) & ~grant & ~resp_err;
    assign req0_err = (state == S_RESP) & ~grant &  resp_err;
    assign req1_ack = (state == S_RESP) &  grant & ~resp_err;
    assign req1_err = (state == S_RESP) &  grant &  resp_err;

endmodule
